// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU request and RAM port signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              read_mem_ir;
  logic [ADDR_W-1:0] mem_radrs_ir;
  logic              read_mem_load;
  logic [ADDR_W-1:0] mem_radrs_ld;
  logic              write_mem;
  logic [ADDR_W-1:0] mem_wadrs;
  logic [DATA_W-1:0] mem_wdata;
  logic              fetch_enabled;
  logic [DATA_W-1:0] instruction_fetch;
  logic              instr_valid;
  logic              read_load_valid;
  logic [DATA_W-1:0] mem_load_data;
  logic              write_store_valid;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              err_overflow;

  modport slave (
    input  read_mem_ir, mem_radrs_ir, read_mem_load, mem_radrs_ld,
    input  write_mem, mem_wadrs, mem_wdata, ram_rdata,
    output fetch_enabled, instruction_fetch, instr_valid, read_load_valid,
    output mem_load_data, write_store_valid, ram_en, ram_we, ram_addr,
    output ram_wdata, err_overflow
  );

  modport master (
    output read_mem_ir, mem_radrs_ir, read_mem_load, mem_radrs_ld,
    output write_mem, mem_wadrs, mem_wdata, ram_rdata,
    input  fetch_enabled, instruction_fetch, instr_valid, read_load_valid,
    input  mem_load_data, write_store_valid, ram_en, ram_we, ram_addr,
    input  ram_wdata, err_overflow
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter for fetch, load and store requesters
module mem_port_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STORE, LOAD, FETCH} state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  state_t            state;
  logic              ld_pend;
  logic              st_pend;
  logic [ADDR_W-1:0] ld_addr;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [2:0]        lat_cnt;

  assign bus.fetch_enabled = (state == IDLE) && !ld_pend && !st_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      ld_pend               <= 1'b0;
      st_pend               <= 1'b0;
      ld_addr               <= '0;
      st_addr               <= '0;
      st_data               <= '0;
      lat_cnt               <= '0;
      bus.ram_en            <= 1'b0;
      bus.ram_we            <= 1'b0;
      bus.ram_addr          <= '0;
      bus.ram_wdata         <= '0;
      bus.instruction_fetch <= '0;
      bus.mem_load_data     <= '0;
      bus.instr_valid       <= 1'b0;
      bus.read_load_valid   <= 1'b0;
      bus.write_store_valid <= 1'b0;
      bus.err_overflow      <= 1'b0;
    end else begin
      bus.instr_valid       <= 1'b0;
      bus.read_load_valid   <= 1'b0;
      bus.write_store_valid <= 1'b0;
      bus.ram_en            <= 1'b0;
      bus.ram_we            <= 1'b0;

      // A pulse against an already-set pend bit is lost; the FSM clear below
      // still wins on a completion edge, so the dropped pulse stays dropped.
      if (bus.write_mem) begin
        if (st_pend) begin
          bus.err_overflow <= 1'b1;
        end else begin
          st_pend <= 1'b1;
          st_addr <= bus.mem_wadrs;
          st_data <= bus.mem_wdata;
        end
      end
      if (bus.read_mem_load) begin
        if (ld_pend) begin
          bus.err_overflow <= 1'b1;
        end else begin
          ld_pend <= 1'b1;
          ld_addr <= bus.mem_radrs_ld;
        end
      end

      case (state)
        IDLE: begin
          // Store ahead of load keeps read-after-write order for one address.
          if (st_pend) begin
            bus.ram_en    <= 1'b1;
            bus.ram_we    <= 1'b1;
            bus.ram_addr  <= st_addr;
            bus.ram_wdata <= st_data;
            lat_cnt       <= LAT_INIT;
            state         <= STORE;
          end else if (ld_pend) begin
            bus.ram_en    <= 1'b1;
            bus.ram_addr  <= ld_addr;
            bus.ram_wdata <= '0;
            lat_cnt       <= LAT_INIT;
            state         <= LOAD;
          end else if (bus.read_mem_ir && bus.fetch_enabled) begin
            bus.ram_en    <= 1'b1;
            bus.ram_addr  <= bus.mem_radrs_ir;
            bus.ram_wdata <= '0;
            lat_cnt       <= LAT_INIT;
            state         <= FETCH;
          end
        end
        STORE: begin
          bus.write_store_valid <= 1'b1;
          st_pend               <= 1'b0;
          state                 <= IDLE;
        end
        LOAD: begin
          if (lat_cnt == 3'd0) begin
            bus.mem_load_data   <= bus.ram_rdata;
            bus.read_load_valid <= 1'b1;
            ld_pend             <= 1'b0;
            state               <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        FETCH: begin
          if (lat_cnt == 3'd0) begin
            bus.instruction_fetch <= bus.ram_rdata;
            bus.instr_valid       <= 1'b1;
            state                 <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - bench driving RD_LAT=1 and RD_LAT=3 arbiters against a timing model
module tb_mem_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset   = 1'b1;
  logic          preload = 1'b1;
  logic          rd_ir   = 1'b0;
  logic [AW-1:0] adr_ir  = '0;
  logic          ld      = 1'b0;
  logic [AW-1:0] adr_ld  = '0;
  logic          wr      = 1'b0;
  logic [AW-1:0] adr_w   = '0;
  logic [DW-1:0] wdata   = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  assign bus0.read_mem_ir = rd_ir;  assign bus1.read_mem_ir = rd_ir;
  assign bus0.mem_radrs_ir = adr_ir; assign bus1.mem_radrs_ir = adr_ir;
  assign bus0.read_mem_load = ld;   assign bus1.read_mem_load = ld;
  assign bus0.mem_radrs_ld = adr_ld; assign bus1.mem_radrs_ld = adr_ld;
  assign bus0.write_mem = wr;       assign bus1.write_mem = wr;
  assign bus0.mem_wadrs = adr_w;    assign bus1.mem_wadrs = adr_w;
  assign bus0.mem_wdata = wdata;    assign bus1.mem_wdata = wdata;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return 32'hA5A5_0001;
    if (i == 2047) return 32'hFFFF_FFFF;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0F0F_3C3C;
  endfunction

  // RAM models: one-stage pipe for latency 1, three-stage pipe for latency 3
  logic [DW-1:0] ram0 [2048];
  logic [DW-1:0] ram1 [2048];
  logic [DW-1:0] pipe0;
  logic [DW-1:0] pipe1 [3];
  assign bus0.ram_rdata = pipe0;
  assign bus1.ram_rdata = pipe1[2];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) begin
        ram0[i] <= init_word(i);
        ram1[i] <= init_word(i);
      end
    end else begin
      if (bus0.ram_en) begin
        if (bus0.ram_we) ram0[bus0.ram_addr] <= bus0.ram_wdata;
        pipe0 <= ram0[bus0.ram_addr];
      end
      if (bus1.ram_en) begin
        if (bus1.ram_we) ram1[bus1.ram_addr] <= bus1.ram_wdata;
        pipe1[0] <= ram1[bus1.ram_addr];
      end
      pipe1[1] <= pipe1[0];
      pipe1[2] <= pipe1[1];
    end
  end

  // Transaction-level reference: pend flags, one access in flight, completion edge by arithmetic
  logic [DW-1:0] ref_mem [2][2048];
  bit            busy [2];
  int            kind [2];
  int            done_at [2];
  logic [AW-1:0] cur_addr [2];
  logic [DW-1:0] cur_data [2];
  bit            m_stp [2];
  bit            m_ldp [2];
  logic [AW-1:0] m_st_addr [2];
  logic [DW-1:0] m_st_data [2];
  logic [AW-1:0] m_ld_addr [2];
  bit            e_fe [2], e_en [2], e_we [2], e_iv [2], e_lv [2], e_sv [2], e_ovf [2];
  logic [AW-1:0] e_addr [2];
  logic [DW-1:0] e_wd [2], e_ins [2], e_ldd [2];

  task automatic model_step(input int k);
    bit stp0, ldp0, fe_pre;
    int lat;
    lat = (k == 0) ? 1 : 3;
    if (reset) begin
      busy[k] = 0; m_stp[k] = 0; m_ldp[k] = 0;
      e_en[k] = 0; e_we[k] = 0; e_addr[k] = '0; e_wd[k] = '0;
      e_iv[k] = 0; e_lv[k] = 0; e_sv[k] = 0; e_ins[k] = '0; e_ldd[k] = '0; e_ovf[k] = 0;
    end else begin
      stp0 = m_stp[k];
      ldp0 = m_ldp[k];
      fe_pre = !busy[k] && !stp0 && !ldp0;
      e_en[k] = 0; e_we[k] = 0; e_iv[k] = 0; e_lv[k] = 0; e_sv[k] = 0;
      if (wr) begin
        if (stp0) e_ovf[k] = 1;
        else begin m_stp[k] = 1; m_st_addr[k] = adr_w; m_st_data[k] = wdata; end
      end
      if (ld) begin
        if (ldp0) e_ovf[k] = 1;
        else begin m_ldp[k] = 1; m_ld_addr[k] = adr_ld; end
      end
      if (busy[k] && cyc == done_at[k]) begin
        busy[k] = 0;
        case (kind[k])
          1: begin ref_mem[k][cur_addr[k]] = cur_data[k]; e_sv[k] = 1; m_stp[k] = 0; end
          2: begin e_ldd[k] = ref_mem[k][cur_addr[k]]; e_lv[k] = 1; m_ldp[k] = 0; end
          default: begin e_ins[k] = ref_mem[k][cur_addr[k]]; e_iv[k] = 1; end
        endcase
      end else if (!busy[k] && (stp0 || ldp0 || (rd_ir && fe_pre))) begin
        if (stp0) begin
          kind[k] = 1; cur_addr[k] = m_st_addr[k]; cur_data[k] = m_st_data[k];
          done_at[k] = cyc + 1; e_we[k] = 1; e_wd[k] = m_st_data[k];
        end else if (ldp0) begin
          kind[k] = 2; cur_addr[k] = m_ld_addr[k]; done_at[k] = cyc + 1 + lat; e_wd[k] = '0;
        end else begin
          kind[k] = 3; cur_addr[k] = adr_ir; done_at[k] = cyc + 1 + lat; e_wd[k] = '0;
        end
        busy[k] = 1; e_en[k] = 1; e_addr[k] = cur_addr[k];
      end
    end
    e_fe[k] = !busy[k] && !m_stp[k] && !m_ldp[k];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all(input int k);
    logic fe, en, we, iv, lv, sv, ov;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, ins, ldd;
    if (k == 0) begin
      fe = bus0.fetch_enabled; en = bus0.ram_en; we = bus0.ram_we; iv = bus0.instr_valid;
      lv = bus0.read_load_valid; sv = bus0.write_store_valid; ov = bus0.err_overflow;
      a = bus0.ram_addr; wd = bus0.ram_wdata; ins = bus0.instruction_fetch; ldd = bus0.mem_load_data;
    end else begin
      fe = bus1.fetch_enabled; en = bus1.ram_en; we = bus1.ram_we; iv = bus1.instr_valid;
      lv = bus1.read_load_valid; sv = bus1.write_store_valid; ov = bus1.err_overflow;
      a = bus1.ram_addr; wd = bus1.ram_wdata; ins = bus1.instruction_fetch; ldd = bus1.mem_load_data;
    end
    chk($sformatf("d%0d_fetch_enabled", k), 64'(fe), 64'(e_fe[k]));
    chk($sformatf("d%0d_ram_en", k), 64'(en), 64'(e_en[k]));
    chk($sformatf("d%0d_ram_we", k), 64'(we), 64'(e_we[k]));
    chk($sformatf("d%0d_instr_valid", k), 64'(iv), 64'(e_iv[k]));
    chk($sformatf("d%0d_read_load_valid", k), 64'(lv), 64'(e_lv[k]));
    chk($sformatf("d%0d_write_store_valid", k), 64'(sv), 64'(e_sv[k]));
    chk($sformatf("d%0d_err_overflow", k), 64'(ov), 64'(e_ovf[k]));
    chk($sformatf("d%0d_instruction_fetch", k), 64'(ins), 64'(e_ins[k]));
    chk($sformatf("d%0d_mem_load_data", k), 64'(ldd), 64'(e_ldd[k]));
    if (e_en[k] || reset) begin
      chk($sformatf("d%0d_ram_addr", k), 64'(a), 64'(e_addr[k]));
      chk($sformatf("d%0d_ram_wdata", k), 64'(wd), 64'(e_wd[k]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step(0);
    model_step(1);
    #1;
    check_all(0);
    check_all(1);
    @(negedge clk);
    wr = 1'b0;
    ld = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 2048; i++) ref_mem[k][i] = init_word(i);

    run(3);
    chk("rst_fetch_enabled", 64'(bus1.fetch_enabled), 64'd1);
    preload = 1'b0;
    reset = 1'b0;
    run(1);

    rd_ir = 1'b1; adr_ir = 11'h005;
    run(8);
    rd_ir = 1'b0;
    run(6);
    chk("fetch0_data", 64'(bus0.instruction_fetch), 64'hA5A5_0001);
    chk("fetch1_data", 64'(bus1.instruction_fetch), 64'hA5A5_0001);

    wr = 1'b1; adr_w = 11'h010; wdata = 32'hDEAD_BEEF;
    run(8);
    chk("store_ram0", 64'(ram0[16]), 64'hDEAD_BEEF);

    wr = 1'b1; adr_w = 11'h020; wdata = 32'h1234_5678;
    ld = 1'b1; adr_ld = 11'h020;
    run(12);
    chk("raw0_data", 64'(bus0.mem_load_data), 64'h1234_5678);
    chk("raw1_data", 64'(bus1.mem_load_data), 64'h1234_5678);

    ld = 1'b1; adr_ld = 11'h7FF;
    run(10);
    chk("load7ff_data", 64'(bus1.mem_load_data), 64'hFFFF_FFFF);

    ld = 1'b1; adr_ld = 11'h100;
    run(1);
    ld = 1'b1; adr_ld = 11'h200;
    run(10);
    chk("ovf0_flag", 64'(bus0.err_overflow), 64'd1);
    chk("ovf1_flag", 64'(bus1.err_overflow), 64'd1);
    chk("ovf1_first_load", 64'(bus1.mem_load_data), 64'(init_word(32'h100)));

    ld = 1'b1; adr_ld = 11'h300;
    run(2);
    reset = 1'b1;
    run(1);
    chk("rstld_fetch_enabled", 64'(bus1.fetch_enabled), 64'd1);
    chk("rstld_load_data", 64'(bus1.mem_load_data), 64'd0);
    chk("rstld_overflow", 64'(bus1.err_overflow), 64'd0);
    reset = 1'b0;
    run(8);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) rd_ir = ~rd_ir;
      adr_ir = 11'($urandom_range(0, 2047));
      wr     = ($urandom_range(0, 7) == 0);
      adr_w  = 11'($urandom_range(0, 63));
      wdata  = $urandom;
      ld     = ($urandom_range(0, 7) == 0);
      adr_ld = 11'($urandom_range(0, 63));
      reset  = (n == 200);
      cycle();
    end
    reset = 1'b0;
    rd_ir = 1'b0;
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
